sal_seq_n: RTL and testbench

//   Sequential saturating arithmetic LEFT shifter (SAL), the up-scaling counterpart of the

---
 rtl/sal_pkg.sv | 26 ++
 rtl/sal_step_n.sv | 15 +
 rtl/sal_seq_n.sv | 136 +++++++++++++
 tb/tb_sal_seq_n.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sal_pkg.sv
// Shared definitions for the sequential saturating arithmetic left shifter.
// Holds the state encoding, the sample-width helper and the saturation constants.
package sal_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Sample width in bits for a given log2 width
  function automatic int width_of(input int n);
    return 2 ** n;
  endfunction

  // Largest positive two's complement value of width w, right-aligned in 64 bits
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value of width w, right-aligned in 64 bits
  function automatic logic [63:0] max_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sal_step_n.sv
// One combinational 1-bit arithmetic left step.
// step_ovf_o flags that the step drops a significant bit, which happens when the
// two top bits differ before the shift.
module sal_step_n #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc_i,
  output logic [W-1:0] acc_o,
  output logic         step_ovf_o
);

  assign acc_o      = {acc_i[W-2:0], 1'b0};
  assign step_ovf_o = acc_i[W-1] ^ acc_i[W-2];

endmodule

// File: rtl/sal_seq_n.sv
// Sequential saturating arithmetic left shifter: one bit of left shift per clock,
// with sticky per-sample overflow and valid/ready handshakes on both sides.
// Optional build macro: SAL_SATURATE_EN clamps the result to the most positive or
// most negative value when overflow occurred; without it the result wraps.
module sal_seq_n
  import sal_pkg::*;
#(
  parameter int N   = 4,
  parameter int SHW = N,
  localparam int W  = width_of(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [SHW-1:0] in_shft,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_ovf
);

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [W-1:0]   stepAcc;
  logic           stepOvf;

  sal_step_n #(.W(W)) uStep (
    .acc_i      (acc_q),
    .acc_o      (stepAcc),
    .step_ovf_o (stepOvf)
  );

  // State register; reset drops any partially shifted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: zero shift skips straight to DONE, otherwise shift until the last bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = (in_shft != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == SHW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: accumulator, remaining-step counter and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Datapath next values: load on accept, one shift step per SHIFT cycle, hold otherwise
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d = in_data;
          cnt_d = in_shft;
          ovf_d = 1'b0;
        end
      end
      S_SHIFT: begin
        acc_d = stepAcc;
        cnt_d = cnt_q - SHW'(1);
        ovf_d = ovf_q | stepOvf;
      end
      default: ;
    endcase
  end

`ifdef SAL_SATURATE_EN
  logic sign_q;

  // Original sign of the sample picks the clamp direction on overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else if (state_q == S_IDLE && in_valid) begin
      sign_q <= in_data[W-1];
    end
  end

  // Outputs decoded from state; overflowed samples clamp to the signed extreme
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out_ovf   = ovf_q;
    out_data  = acc_q;
    if (ovf_q) begin
      out_data = sign_q ? W'(max_neg(W)) : W'(max_pos(W));
    end
  end
`else
  // Outputs decoded from state; overflowed samples simply wrap
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out_ovf   = ovf_q;
    out_data  = acc_q;
  end
`endif

endmodule

// File: tb/tb_sal_seq_n.sv
// Directed testbench for sal_seq_n at N=4 (16-bit samples).
// Expected values for overflowing samples follow SAL_SATURATE_EN when it is defined.
module tb_sal_seq_n;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shft;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int checkCount;
  int errorCount;
  int lat;

  sal_seq_n #(.N(4), .SHW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shft   (in_shft),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offer one sample, wait for out_valid (bounded) and report latency in edges from accept
  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] shft,
                               input bit holdValid, output int latency);
    @(negedge clk);
    in_data  = data;
    in_shft  = shft;
    in_valid = 1'b1;
    checkOutput("accept_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    latency = 1;
    @(negedge clk);
    if (holdValid) begin
      in_data = ~data;
      in_shft = 4'd1;
    end else begin
      in_valid = 1'b0;
    end
    while (!out_valid && latency < 40) begin
      @(posedge clk);
      latency++;
      @(negedge clk);
      if (!out_valid) begin
        checkOutput("busy_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      checkOutput("out_valid_timeout", 32'd0, 32'd1);
    end
  endtask

  // Complete the output handshake and confirm return to IDLE
  task automatic finishHandshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    checkOutput({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 16'h0;
    in_shft    = 4'h0;
    out_ready  = 1'b0;

    // Reset state, with a stray in_valid that must be ignored
    #12;
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    #10;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", {16'd0, out_data}, 32'h0);
    checkOutput("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: plain shift by 4, latency k+1 = 5
    applyStimulus(16'h0003, 4'd4, 1'b0, lat);
    checkOutput("t1_latency", 32'(lat), 32'd5);
    checkOutput("t1_data", {16'd0, out_data}, 32'h0030);
    checkOutput("t1_ovf", {31'd0, out_ovf}, 32'd0);
    finishHandshake("t1");

    // 2: negative sample, out_ready held high throughout
    out_ready = 1'b1;
    applyStimulus(16'hFFF0, 4'd3, 1'b0, lat);
    checkOutput("t2_latency", 32'(lat), 32'd4);
    checkOutput("t2_data", {16'd0, out_data}, 32'hFF80);
    checkOutput("t2_ovf", {31'd0, out_ovf}, 32'd0);
    finishHandshake("t2");

    // 3: positive overflow, in_valid held high while busy
    applyStimulus(16'h4000, 4'd1, 1'b1, lat);
    checkOutput("t3_ovf", {31'd0, out_ovf}, 32'd1);
`ifdef SAL_SATURATE_EN
    checkOutput("t3_data", {16'd0, out_data}, 32'h7FFF);
`else
    checkOutput("t3_data", {16'd0, out_data}, 32'h8000);
`endif
    finishHandshake("t3");

    // 4: negative overflow
    applyStimulus(16'h8000, 4'd2, 1'b0, lat);
    checkOutput("t4_ovf", {31'd0, out_ovf}, 32'd1);
`ifdef SAL_SATURATE_EN
    checkOutput("t4_data", {16'd0, out_data}, 32'h8000);
`else
    checkOutput("t4_data", {16'd0, out_data}, 32'h0000);
`endif
    finishHandshake("t4");

    // 5: zero shift with downstream stall, result held stable
    applyStimulus(16'h1234, 4'd0, 1'b0, lat);
    checkOutput("t5_latency", 32'(lat), 32'd1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("t5_hold_data", {16'd0, out_data}, 32'h1234);
      checkOutput("t5_hold_ovf", {31'd0, out_ovf}, 32'd0);
      checkOutput("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    finishHandshake("t5");

    // Boundary: zero sample shifted stays zero
    applyStimulus(16'h0000, 4'd5, 1'b0, lat);
    checkOutput("zero_data", {16'd0, out_data}, 32'h0000);
    checkOutput("zero_ovf", {31'd0, out_ovf}, 32'd0);
    finishHandshake("zero");

    // Boundary: -1 shifted by W-1 reaches most negative without overflow
    applyStimulus(16'hFFFF, 4'd15, 1'b0, lat);
    checkOutput("m1_latency", 32'(lat), 32'd16);
    checkOutput("m1_data", {16'd0, out_data}, 32'h8000);
    checkOutput("m1_ovf", {31'd0, out_ovf}, 32'd0);
    finishHandshake("m1");

    // 6: reset in the middle of a long shift discards the partial result
    @(negedge clk);
    in_data  = 16'h0001;
    in_shft  = 4'd15;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("t6_rst_data", {16'd0, out_data}, 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("t6_no_stale", {31'd0, out_valid}, 32'd0);
    end
    applyStimulus(16'h0005, 4'd2, 1'b0, lat);
    checkOutput("t6_data", {16'd0, out_data}, 32'h0014);
    checkOutput("t6_ovf", {31'd0, out_ovf}, 32'd0);
    finishHandshake("t6");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
